uart_byte_fifo: RTL

Byte buffer between the UART receiver and the UART transmitter in the loopback datapath (50 MHz `sys_clk`, 115200 baud, 8N1). It absorbs received bytes, strobed by the receiver's one-cycle done pulse, into a circular FIFO. A small read-side state machine hands the bytes one at a time to the transmitter using its busy flag. Received bytes are therefore not lost while the transmitter is still shifting out an earlier byte.

---
 rtl/uart_byte_fifo.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte FIFO between the UART receiver and transmitter.
// Received bytes are absorbed on the receiver's done pulse. A read-side FSM
// hands them one at a time to the transmitter, using its busy flag as handshake.
// Optional feature: define UART_FIFO_OVF_CNT_EN to add ovf_cnt, an 8-bit
// saturating count of dropped bytes that is cleared only by reset.
module uart_byte_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                rx_done,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                tx_busy,
   output logic                tx_en,
   output logic [DATA_W-1:0]   tx_data,
   output logic [DEPTH_LOG2:0] fifo_cnt,
   output logic                full,
   output logic                empty,
   output logic                overflow
`ifdef UART_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]          ovf_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FIRE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            timer_q, timer_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]     tx_data_q, tx_data_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_W-1:0]     mem_q [DEPTH];

   logic pop;
   logic wr_en;
   logic drop;

   // Status comes from the registered count, so it never depends on this cycle's inputs.
   assign full  = (cnt_q == DEPTH_CNT);
   assign empty = (cnt_q == '0);

   // A pop makes room on the same edge, so a write while full is still accepted then.
   assign pop   = (state_q == S_IDLE) && !empty && !tx_busy;
   assign wr_en = rx_done && (!full || pop);
   assign drop  = rx_done && full && !pop;

   assign tx_data  = tx_data_q;
   assign fifo_cnt = cnt_q;
   assign overflow = overflow_q;

   // Next pointers, occupancy, output byte and overflow flag.
   // NOTE: combinational blocks use blocking '=' with every output defaulted
   // first (no latches); clocked blocks use non-blocking '<=' only.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      overflow_d = drop;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         tx_data_d = mem_q[rd_ptr_q];
      end
      if (wr_en && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !wr_en) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Read-side handshake FSM: one byte in flight, with lost-busy recovery.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      tx_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pop) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_FIRE;
         end
         S_FIRE: begin
            tx_en   = 1'b1;
            timer_d = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (timer_q == 2'd3) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

   // Byte storage.
   // NOTE: the RAM has no reset. Clearing the pointers and count already
   // discards its contents, and a reset here would stop it mapping onto RAM.
   always_ff @(posedge sys_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= rx_data;
   end

`ifdef UART_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   // Saturating count of dropped bytes.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 1'b1;
   end

   // Dropped-byte counter register, cleared only by reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) ovf_cnt_q <= '0;
      else            ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
